instruction_queue: RTL

- Fetch-and-buffer stage directly upstream of the reorder buffer.
- Issues sequential instruction-memory reads and applies static branch prediction to select the next fetch PC.
- Decodes each returned word into a pci_t and buffers it in a circular FIFO drained by the reorder buffer's instr_q_dequeue.
- On a flush it discards all buffered and in-flight instructions and redirects fetch to flush_pc.

---
 rtl/instruction_queue.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/instruction_queue.sv
// Fetch-and-buffer stage: issues sequential instruction fetches with static branch
// prediction, decodes returned words into pci_t and buffers them for the reorder buffer.
package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] branch_pc;
        logic        br_pred;
        rv32i_opcode opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } pci_t;
endpackage

module instruction_queue
    import rv32i_types::*;
#(
    parameter int                width    = 32,
    parameter int                size     = 8,
    parameter logic [width-1:0]  reset_pc = 32'h00000060
) (
    input  logic             clk,
    input  logic             rst,
    output logic [width-1:0] instr_mem_address,
    output logic             instr_mem_read,
    input  logic [width-1:0] instr_mem_rdata,
    input  logic             instr_mem_resp,
    input  logic             instr_q_dequeue,
    input  logic             flush_valid,
    input  logic [width-1:0] flush_pc,
    output pci_t             pci,
    output logic             instr_q_empty,
    output logic             instr_q_full
);
    localparam int             pw       = $clog2(size);
    localparam int             cw       = pw + 1;
    localparam logic [cw-1:0]  full_cnt = cw'(size);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, DISCARD} state_t;

    state_t          state_r, state_s;
    logic [width-1:0] fetch_pc_r, fetch_pc_s;
    logic [width-1:0] redirect_r, redirect_s;
    logic [pw-1:0]    head_r, tail_r;
    logic [cw-1:0]    count_r, count_s;
    pci_t             entries_r [size];
    pci_t             resp_pci_s;
    logic             bypass_s, wr_s, deq_s;

    function automatic pci_t reset_pci();
        pci_t p;
        p        = '0;
        p.opcode = op_imm;
        return p;
    endfunction

    function automatic pci_t decode(input logic [31:0] w, input logic [31:0] pc);
        pci_t        p;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = {{20{w[31]}}, w[31:20]};
        imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        imm_u = {w[31:12], 12'h000};
        imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        p           = '0;
        p.pc        = pc;
        p.opcode    = rv32i_opcode'(w[6:0]);
        p.rd        = w[11:7];
        p.funct3    = w[14:12];
        p.rs1       = w[19:15];
        p.rs2       = w[24:20];
        p.funct7    = w[31:25];
        p.branch_pc = pc + 32'd4;
        p.br_pred   = 1'b0;
        case (p.opcode)
            op_lui, op_auipc: p.imm = imm_u;
            op_store:         p.imm = imm_s;
            op_reg:           p.imm = 32'd0;
            op_jal: begin
                p.imm       = imm_j;
                p.branch_pc = pc + imm_j;
                p.br_pred   = 1'b1;
            end
            op_br: begin
                // Backward branches are predicted taken
                p.imm       = imm_b;
                p.branch_pc = pc + imm_b;
                p.br_pred   = imm_b[31];
            end
            default:          p.imm = imm_i;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] next_pc(input pci_t p);
        return p.br_pred ? p.branch_pc : (p.pc + 32'd4);
    endfunction

    // Response decode, bypass detection and FIFO occupancy update
    always_comb begin
        resp_pci_s = decode(instr_mem_rdata, fetch_pc_r);
        bypass_s   = (state_r == FETCH) && (count_r == '0) && instr_mem_resp && !flush_valid;
        wr_s       = (state_r == FETCH) && instr_mem_resp && !flush_valid
                     && !(bypass_s && instr_q_dequeue);
        deq_s      = instr_q_dequeue && !flush_valid && (count_r != '0);
        count_s    = count_r;
        if (flush_valid) begin
            count_s = '0;
        end else if (wr_s && !deq_s) begin
            count_s = count_r + cw'(1);
        end else if (!wr_s && deq_s) begin
            count_s = count_r - cw'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Fetch FSM next state, next fetch PC and redirect latch
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        redirect_s = redirect_r;
        case (state_r)
            IDLE: begin
                state_s    = FETCH;
                fetch_pc_s = flush_valid ? flush_pc : fetch_pc_r;
            end
            FETCH: begin
                if (flush_valid && instr_mem_resp) begin
                    fetch_pc_s = flush_pc;
                end else if (flush_valid) begin
                    state_s    = DISCARD;
                    redirect_s = flush_pc;
                end else if (instr_mem_resp) begin
                    fetch_pc_s = next_pc(resp_pci_s);
                    state_s    = (count_s == full_cnt) ? STALL : FETCH;
                end else begin
                    state_s = FETCH;
                end
            end
            STALL: begin
                if (flush_valid) begin
                    state_s    = FETCH;
                    fetch_pc_s = flush_pc;
                end else if (count_s != full_cnt) begin
                    state_s = FETCH;
                end else begin
                    state_s = STALL;
                end
            end
            DISCARD: begin
                // The newest flush target wins; the in-flight address stays on the bus
                redirect_s = flush_valid ? flush_pc : redirect_r;
                if (instr_mem_resp) begin
                    state_s    = FETCH;
                    fetch_pc_s = redirect_s;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control state and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= reset_pc;
            redirect_r <= reset_pc;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            redirect_r <= redirect_s;
            count_r    <= count_s;
            head_r     <= flush_valid ? '0 : (deq_s ? head_r + pw'(1) : head_r);
            tail_r     <= flush_valid ? '0 : (wr_s ? tail_r + pw'(1) : tail_r);
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < size; i++) begin
                entries_r[i] <= reset_pci();
            end
        end else if (wr_s) begin
            entries_r[tail_r] <= resp_pci_s;
        end else begin
            entries_r[tail_r] <= entries_r[tail_r];
        end
    end

    assign instr_mem_read    = (state_r == FETCH) || (state_r == DISCARD);
    assign instr_mem_address = fetch_pc_r;
    assign instr_q_empty     = (count_r == '0);
    assign instr_q_full      = (count_r == full_cnt);
    assign pci               = bypass_s ? resp_pci_s : entries_r[head_r];
endmodule
